feedback_pkt_gen: RTL
=====================

Name: feedback_pkt_gen

Overview:
Parametrised feedback-packet builder for the Q-routing node. On a start pulse it assembles the 5-field feedback packet and streams it one word per handshake to the packet transmit path: fsourceID, fbatteryStat, fValue, fclusterID, fdestinationID. Memory-sourced fields come from the node's shared data memory. It adds per-field enable, configurable memory latency and address map, and valid/ready backpressure.

Parameters:
WORD_WIDTH, 16, data word width.
ADDR_WIDTH, 16, memory address width.
BATT_BASE, 'h148, base address of the battery-status table, indexed by node_id.
QVAL_BASE, 'h1C8, base address of the Q-value table, indexed by besthop.
NEIGH_BASE, 'h48, base address of the neighbour-ID table, indexed by action.
STRIDE, 2, address increment per table entry.
MEM_LAT, 1, memory read latency in cycles (legal 1..4).
FIELD_MASK, 5'b11111, bit i enables field i (0 SRC, 1 BATT, 2 QVAL, 3 CLUS, 4 DEST).

Ports:
clock  in  1  system clock, rising edge.
nreset  in  1  asynchronous active-low reset.
start  in  1  request to build one packet; sampled only in IDLE.
node_id  in  WORD_WIDTH  own node ID; latched on accepted start.
cluster_id  in  WORD_WIDTH  own cluster ID; latched on accepted start.
besthop  in  WORD_WIDTH  best-hop index; latched on accepted start.
action  in  WORD_WIDTH  chosen action index; latched on accepted start.
mem_addr  out  ADDR_WIDTH  read address, registered.
mem_rd  out  1  read strobe, one cycle per read.
mem_rdata  in  WORD_WIDTH  read data, valid MEM_LAT cycles after the mem_rd cycle.
out_data  out  WORD_WIDTH  packet word.
out_valid  out  1  out_data valid.
out_ready  in  1  consumer accepts the word when out_valid && out_ready.
out_idx  out  3  field index of the current word.
out_last  out  1  current word is the last enabled field.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset is asynchronous, active-low, nreset. Clock is clock. Reset clears every output and register to 0, puts the FSM in IDLE, and clears the field index. Reset mid-packet aborts the packet; no done is generated.
- States: IDLE, OUT, REQ, WAIT.
- IDLE: on start, latch the four inputs and select the lowest enabled field.
  - If FIELD_MASK==0: no word is emitted and done pulses the next cycle.
  - start in any non-IDLE state is ignored; it is not queued.
- Constant field (SRC, CLUS): go to OUT with out_data = latched node_id or cluster_id.
- Memory field: go to REQ.
  - REQ: mem_rd=1 for exactly this cycle.
  - mem_addr = BASE + index*STRIDE, truncated mod 2^ADDR_WIDTH. BATT uses node_id, QVAL uses besthop, DEST uses action.
  - mem_addr holds its value until the next REQ.
  - WAIT lasts MEM_LAT cycles. mem_rdata is captured into a holding register on the last WAIT cycle, then the FSM goes to OUT.
- OUT: out_valid=1. out_data, out_idx and out_last stay stable until the handshake.
  - On handshake: if out_last, return to IDLE and pulse done next cycle. Otherwise advance to the next enabled field (OUT or REQ).
  - No memory re-read occurs while the FSM is stalled in OUT.
- Latency with MEM_LAT=1, all fields enabled, out_ready high, start in cycle 0:
  - words are valid in cycles 1 (SRC), 4 (BATT), 7 (QVAL), 8 (CLUS), 11 (DEST);
  - done is high in cycle 12.
  - Each stall cycle in OUT adds one cycle.
- done cycle: the FSM is already IDLE, so a start in the done cycle is accepted.
- Skipped (disabled) fields cost zero cycles and generate no memory access.

Test Plan:
- Default params; memory preloaded 0x14E=0x00AA, 0x1D2=0x0BEE, 0x4C=0x0007; node_id=3, cluster_id=0x11, besthop=5, action=2, out_ready=1, start at cycle 0 -> words 0x0003, 0x00AA, 0x0BEE, 0x0011, 0x0007 in cycles 1/4/7/8/11; out_last only on 0x0007; done in cycle 12.
- Same as the first test with out_ready low for 4 cycles while QVAL is presented -> out_data=0x0BEE held stable, mem_rd not reasserted, done in cycle 16.
- FIELD_MASK=5'b10011 -> words SRC, BATT, DEST only, with out_idx 0, 1, 4 and out_last on DEST. FIELD_MASK=0 with start -> no out_valid, done in cycle 1.
- start pulsed in cycle 5 of a packet -> ignored, single packet output. start in the done cycle -> second packet begins, SRC valid the next cycle.
- node_id=0xFFFF -> BATT read at mem_addr=0x0146 (wrap). MEM_LAT=3 -> each memory word is delayed 2 extra cycles versus the first test.
- nreset asserted during BATT WAIT -> all outputs 0 immediately, no done. After release, a new start produces the full first-test sequence.

Source files
------------

// File: rtl/feedback_pkt_gen.sv
// Feedback-packet builder: streams SRC, BATT, QVAL, CLUS, DEST words over a
// valid/ready port, fetching the table-backed fields from shared data memory.
module feedback_pkt_gen #(
    parameter int         WORD_WIDTH = 16,
    parameter int         ADDR_WIDTH = 16,
    parameter int         BATT_BASE  = 'h148,
    parameter int         QVAL_BASE  = 'h1C8,
    parameter int         NEIGH_BASE = 'h48,
    parameter int         STRIDE     = 2,
    parameter int         MEM_LAT    = 1,
    parameter logic [4:0] FIELD_MASK = 5'b11111
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] node_id,
    input  logic [WORD_WIDTH-1:0] cluster_id,
    input  logic [WORD_WIDTH-1:0] besthop,
    input  logic [WORD_WIDTH-1:0] action,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, OUT, REQ, WAIT} state_t;

    localparam logic [2:0] F_SRC  = 3'd0;
    localparam logic [2:0] F_BATT = 3'd1;
    localparam logic [2:0] F_QVAL = 3'd2;
    localparam logic [2:0] F_CLUS = 3'd3;
    localparam logic [2:0] F_DEST = 3'd4;
    localparam logic [2:0] F_NONE = 3'd5;

    state_t                state_q;
    logic [2:0]            field_q;
    logic [1:0]            wait_q;
    logic [WORD_WIDTH-1:0] node_q, cluster_q, besthop_q, action_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_rd_q;
    logic [WORD_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic [2:0]            out_idx_q;
    logic                  out_last_q;
    logic                  done_q;

    logic                  advance;
    logic [2:0]            field_d;
    logic                  last_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [WORD_WIDTH-1:0] node_sel, cluster_sel, besthop_sel, action_sel;

    // Lowest enabled field at or above 'from'; F_NONE when nothing is left.
    function automatic logic [2:0] first_field(input logic [2:0] from);
        logic [2:0] f;
        f = F_NONE;
        for (int i = 4; i >= 0; i--)
            if (FIELD_MASK[i] && (3'(i) >= from)) f = 3'(i);
        return f;
    endfunction

    function automatic logic is_last(input logic [2:0] f);
        logic last;
        last = 1'b1;
        for (int i = 0; i < 5; i++)
            if (FIELD_MASK[i] && (3'(i) > f)) last = 1'b0;
        return last;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] table_addr(input int base,
                                                         input logic [WORD_WIDTH-1:0] index);
        return ADDR_WIDTH'(base) + ADDR_WIDTH'(index) * ADDR_WIDTH'(STRIDE);
    endfunction

    // In IDLE the inputs are being latched this very cycle, so use them directly.
    always_comb begin
        node_sel    = (state_q == IDLE) ? node_id    : node_q;
        cluster_sel = (state_q == IDLE) ? cluster_id : cluster_q;
        besthop_sel = (state_q == IDLE) ? besthop    : besthop_q;
        action_sel  = (state_q == IDLE) ? action     : action_q;
        advance     = ((state_q == IDLE) && start) || ((state_q == OUT) && out_ready);
        field_d     = (state_q == IDLE) ? first_field(F_SRC) : first_field(field_q + 3'd1);
        last_d      = is_last(field_d);
        case (field_d)
            F_BATT:  addr_d = table_addr(BATT_BASE, node_sel);
            F_QVAL:  addr_d = table_addr(QVAL_BASE, besthop_sel);
            F_DEST:  addr_d = table_addr(NEIGH_BASE, action_sel);
            default: addr_d = mem_addr_q;
        endcase
    end

    // NOTE: asynchronous reset sits in the sensitivity list; every register,
    // including the latched inputs, returns to a known value.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            field_q     <= '0;
            wait_q      <= '0;
            node_q      <= '0;
            cluster_q   <= '0;
            besthop_q   <= '0;
            action_q    <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_rd_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    node_q    <= node_id;
                    cluster_q <= cluster_id;
                    besthop_q <= besthop;
                    action_q  <= action;
                end
                REQ: begin
                    state_q <= WAIT;
                    wait_q  <= '0;
                end
                WAIT: if (wait_q == 2'(MEM_LAT - 1)) begin
                    out_data_q  <= mem_rdata;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end else begin
                    wait_q <= wait_q + 2'd1;
                end
                OUT: if (out_ready) out_valid_q <= 1'b0;
                default: state_q <= IDLE;
            endcase
            // NOTE: these non-blocking writes come after the case on purpose; the
            // last assignment in the block wins, so entering a field overrides
            // the defaults set above.
            if (advance) begin
                if (field_d == F_NONE) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    field_q    <= field_d;
                    out_idx_q  <= field_d;
                    out_last_q <= last_d;
                    if (field_d == F_SRC || field_d == F_CLUS) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= (field_d == F_SRC) ? node_sel : cluster_sel;
                    end else begin
                        state_q    <= REQ;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= addr_d;
                    end
                end
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
